// File: rtl/mux_seq_reg.sv
// Registered N-channel multiplexer with held select, round-robin AUTO scan and post-switch blanking.
// Optional source-parity checking and output parity are enabled with `define MUX_SEQ_PARITY_EN.
module mux_seq_reg #(
    parameter int NCH   = 4,
    parameter int W     = 8,
    parameter int SW    = 2,
    parameter int DWELL = 16,
    parameter int BLANK = 2
) (
    input  logic             CK,
    input  logic             LSR,
    input  logic             CE,
    input  logic [NCH*W-1:0] D,
    input  logic [SW-1:0]    SD,
    input  logic             LD,
    input  logic             AUTO,
`ifdef MUX_SEQ_PARITY_EN
    input  logic [NCH-1:0]   PI,
    output logic             ZP,
`endif
    output logic [W-1:0]     Z,
    output logic             ZV,
    output logic [SW-1:0]    CH,
    output logic             SERR
);

    localparam logic [SW:0]   NCH_L      = (SW+1)'(NCH);
    localparam logic [SW-1:0] CH_LAST    = SW'(NCH - 1);
    localparam logic [15:0]   DWELL_LAST = 16'(DWELL - 1);
    localparam logic [3:0]    BLANK_L    = 4'(BLANK);

    logic [15:0]   dwell_cnt, dwell_next;
    logic [3:0]    blank_cnt, blank_next;
    logic [SW-1:0] ch_next;
    logic          change;
    logic          sd_bad;
    logic          par_err;
    logic [W-1:0]  sel_data;

    // Data is taken from the channel selected before the edge, so a switch
    // shows up on Z one CE edge after CH moves.
    assign sel_data = D[int'(CH)*W +: W];

`ifdef MUX_SEQ_PARITY_EN
    assign par_err = ZV && (PI[CH] != ^sel_data);
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        ch_next    = CH;
        dwell_next = dwell_cnt;
        change     = 1'b0;
        sd_bad     = 1'b0;
        if (LD) begin
            if ({1'b0, SD} < NCH_L) begin
                ch_next    = SD;
                dwell_next = '0;
                change     = 1'b1;
            end else begin
                sd_bad = 1'b1;
            end
        end else if (AUTO) begin
            if (dwell_cnt == DWELL_LAST) begin
                ch_next    = (CH == CH_LAST) ? '0 : CH + 1'b1;
                dwell_next = '0;
                change     = 1'b1;
            end else begin
                dwell_next = dwell_cnt + 16'd1;
            end
        end
        // A change reloads rather than extends, so overlapping switches never accumulate.
        if (change) begin
            blank_next = BLANK_L;
        end else if (blank_cnt != 4'd0) begin
            blank_next = blank_cnt - 4'd1;
        end else begin
            blank_next = blank_cnt;
        end
    end

    always_ff @(posedge CK) begin
        if (LSR) begin
            CH        <= '0;
            Z         <= '0;
            ZV        <= 1'b0;
            SERR      <= 1'b0;
            dwell_cnt <= '0;
            blank_cnt <= BLANK_L;
        end else if (CE) begin
            CH        <= ch_next;
            Z         <= sel_data;
            ZV        <= (blank_next == 4'd0);
            dwell_cnt <= dwell_next;
            blank_cnt <= blank_next;
            if (sd_bad || par_err) begin
                SERR <= 1'b1;
            end
        end
    end

`ifdef MUX_SEQ_PARITY_EN
    always_ff @(posedge CK) begin
        if (LSR) begin
            ZP <= 1'b0;
        end else if (CE) begin
            ZP <= ^sel_data;
        end
    end
`endif

endmodule

// File: tb/tb_mux_seq_reg.sv
// Bench for mux_seq_reg: a 4-channel and a 3-channel instance share one stimulus bus;
// directed table, hand sequences for multi-cycle corners, then random runs against a model.
module tb_mux_seq_reg;

    localparam int NA  = 4;
    localparam int NB  = 3;
    localparam int W   = 8;
    localparam int DWA = 3;
    localparam int BLA = 2;
    localparam int DWB = 2;
    localparam int BLB = 3;
    localparam int EW  = 1 + 1 + 2 + W;

    // clock / reset block
    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic        lsr = 1'b1;
    logic        ce = 1'b1;
    logic        ld = 1'b0;
    logic        auto_en = 1'b0;
    logic [1:0]  sd = '0;
    logic [31:0] d = 32'h44332211;

    logic [W-1:0] z_a, z_b;
    logic         zv_a, zv_b, serr_a, serr_b;
    logic [1:0]   ch_a, ch_b;

`ifdef MUX_SEQ_PARITY_EN
    logic [NA-1:0] pi_a;
    logic [NB-1:0] pi_b;
    logic          zp_a, zp_b;
    always_comb begin
        pi_a = '0;
        for (int k = 0; k < NA; k++) pi_a[k] = ^d[k*W +: W];
        pi_b = pi_a[NB-1:0];
    end
`endif

    mux_seq_reg #(.NCH(NA), .W(W), .SW(2), .DWELL(DWA), .BLANK(BLA)) dut_a (
        .CK(ck), .LSR(lsr), .CE(ce), .D(d), .SD(sd), .LD(ld), .AUTO(auto_en),
`ifdef MUX_SEQ_PARITY_EN
        .PI(pi_a), .ZP(zp_a),
`endif
        .Z(z_a), .ZV(zv_a), .CH(ch_a), .SERR(serr_a)
    );

    mux_seq_reg #(.NCH(NB), .W(W), .SW(2), .DWELL(DWB), .BLANK(BLB)) dut_b (
        .CK(ck), .LSR(lsr), .CE(ce), .D(d[NB*W-1:0]), .SD(sd), .LD(ld), .AUTO(auto_en),
`ifdef MUX_SEQ_PARITY_EN
        .PI(pi_b), .ZP(zp_b),
`endif
        .Z(z_b), .ZV(zv_b), .CH(ch_b), .SERR(serr_b)
    );

    // scoreboard
    int checks = 0;
    int passed = 0;
    logic [EW-1:0] exp_q[$];

    function automatic logic [EW-1:0] pack(bit serr_v, bit zv_v, int ch_v, int z_v);
        return {serr_v, zv_v, 2'(ch_v), 8'(z_v)};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act);
        logic [EW-1:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: no expected entry queued, got %h", name, act);
            return;
        end
        want = exp_q.pop_front();
        if (act === want) begin
            passed++;
        end else begin
            $display("FAIL %s: got serr=%0b zv=%0b ch=%0d z=%02h, expected serr=%0b zv=%0b ch=%0d z=%02h",
                     name, act[EW-1], act[EW-2], act[W+1:W], act[W-1:0],
                     want[EW-1], want[EW-2], want[W+1:W], want[W-1:0]);
        end
    endtask

    function automatic logic [EW-1:0] act_a();
        return {serr_a, zv_a, ch_a, z_a};
    endfunction

    function automatic logic [EW-1:0] act_b();
        return {serr_b, zv_b, ch_b, z_b};
    endfunction

    // driver tasks
    task automatic drive(input bit lsr_v, input bit ce_v, input bit ld_v, input int sd_v, input bit au_v);
        lsr     = lsr_v;
        ce      = ce_v;
        ld      = ld_v;
        sd      = 2'(sd_v);
        auto_en = au_v;
        @(posedge ck);
        #1;
    endtask

    task automatic step(input bit on_b, input string name,
                        input bit lsr_v, input bit ce_v, input bit ld_v, input int sd_v, input bit au_v,
                        input bit e_serr, input bit e_zv, input int e_ch, input int e_z);
        exp_q.push_back(pack(e_serr, e_zv, e_ch, e_z));
        drive(lsr_v, ce_v, ld_v, sd_v, au_v);
        check(name, on_b ? act_b() : act_a());
    endtask

    // reference model: elapsed-dwell / remaining-blank bookkeeping in plain integers
    typedef struct {
        int ch;
        int dwell;
        int blank;
        int z;
        bit zv;
        bit serr;
    } mdl_t;

    function automatic mdl_t mdl_step(mdl_t s, int nch, int dwell_len, int blank_len,
                                      bit lsr_v, bit ce_v, bit ld_v, int sd_v, bit au_v, logic [31:0] dv);
        mdl_t n = s;
        bit change = 1'b0;
        if (lsr_v) begin
            n = '{ch: 0, dwell: 0, blank: blank_len, z: 0, zv: 1'b0, serr: 1'b0};
            return n;
        end
        if (!ce_v) return s;
        n.z = int'((dv >> (8 * s.ch)) & 32'hff);
        if (ld_v) begin
            if (sd_v < nch) begin
                n.ch = sd_v;
                n.dwell = 0;
                change = 1'b1;
            end else begin
                n.serr = 1'b1;
            end
        end else if (au_v) begin
            n.dwell = s.dwell + 1;
            if (n.dwell == dwell_len) begin
                n.ch = (s.ch + 1) % nch;
                n.dwell = 0;
                change = 1'b1;
            end
        end
        n.blank = change ? blank_len : (s.blank > 0 ? s.blank - 1 : 0);
        n.zv = (n.blank == 0);
        return n;
    endfunction

    typedef struct {
        bit lsr;
        bit ce;
        bit ld;
        int sd;
        bit au;
        int ch;
        int z;
        bit zv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit l, input bit c, input bit ldv, input int s, input bit a,
                       input int ech, input int ez, input bit ezv);
        vec_t v;
        v = '{lsr: l, ce: c, ld: ldv, sd: s, au: a, ch: ech, z: ez, zv: ezv};
        tbl.push_back(v);
    endtask

    initial begin
        mdl_t ma, mb;
        bit r_lsr, r_ce, r_ld, r_au;
        int r_sd;

        // reset, static select, then AUTO scan with DWELL=3 on the 4-channel instance
        add(1, 1, 0, 0, 0, 0, 'h00, 0);
        add(0, 1, 0, 0, 0, 0, 'h11, 0);
        add(0, 1, 0, 0, 0, 0, 'h11, 1);
        add(0, 1, 1, 2, 0, 2, 'h11, 0);
        add(0, 1, 0, 0, 0, 2, 'h33, 0);
        add(0, 1, 0, 0, 0, 2, 'h33, 1);
        add(0, 1, 1, 0, 1, 0, 'h33, 0);
        add(0, 1, 0, 0, 1, 0, 'h11, 0);
        add(0, 1, 0, 0, 1, 0, 'h11, 1);
        add(0, 1, 0, 0, 1, 1, 'h11, 0);
        add(0, 1, 0, 0, 1, 1, 'h22, 0);
        add(0, 1, 0, 0, 1, 1, 'h22, 1);
        add(0, 1, 0, 0, 1, 2, 'h22, 0);
        add(0, 1, 0, 0, 1, 2, 'h33, 0);
        add(0, 1, 0, 0, 1, 2, 'h33, 1);
        add(0, 1, 0, 0, 1, 3, 'h33, 0);
        add(0, 1, 0, 0, 1, 3, 'h44, 0);
        add(0, 1, 0, 0, 1, 3, 'h44, 1);
        add(0, 1, 0, 0, 1, 0, 'h44, 0);

        d = 32'h44332211;
        for (int i = 0; i < tbl.size(); i++) begin
            step(0, $sformatf("vec%0d", i), tbl[i].lsr, tbl[i].ce, tbl[i].ld, tbl[i].sd, tbl[i].au,
                 0, tbl[i].zv, tbl[i].ch, tbl[i].z);
        end

        // back-to-back LD: blanking reloads on the second load
        step(0, "b2b_ld1",  0, 1, 1, 1, 0, 0, 0, 1, 'h11);
        step(0, "b2b_ld3",  0, 1, 1, 3, 0, 0, 0, 3, 'h22);
        step(0, "b2b_hold", 0, 1, 0, 0, 0, 0, 0, 3, 'h44);
        step(0, "b2b_valid", 0, 1, 0, 0, 0, 0, 1, 3, 'h44);

        // CE low during blanking in AUTO: inputs ignored, everything frozen
        step(0, "ce_load", 0, 1, 1, 1, 1, 0, 0, 1, 'h44);
        d = 32'hAABBCCDD;
        for (int i = 0; i < 5; i++) begin
            step(0, $sformatf("ce_frozen%0d", i), 0, 0, 1, 2, 1, 0, 0, 1, 'h44);
        end
        d = 32'h44332211;
        step(0, "ce_resume1", 0, 1, 0, 0, 1, 0, 0, 1, 'h22);
        step(0, "ce_resume2", 0, 1, 0, 0, 1, 0, 1, 1, 'h22);
        step(0, "ce_step",    0, 1, 0, 0, 1, 0, 0, 2, 'h22);

        // LSR mid-scan at CH=2 with ZV=1
        step(0, "scan_c2a",  0, 1, 0, 0, 1, 0, 0, 2, 'h33);
        step(0, "scan_c2b",  0, 1, 0, 0, 1, 0, 1, 2, 'h33);
        step(0, "lsr_abort", 1, 1, 0, 0, 1, 0, 0, 0, 'h00);
        step(0, "lsr_rel1",  0, 1, 0, 0, 0, 0, 0, 0, 'h11);
        step(0, "lsr_rel2",  0, 1, 0, 0, 0, 0, 1, 0, 'h11);

        // illegal select on the 3-channel instance (BLANK=3)
        step(1, "ill_rst",  1, 1, 0, 0, 0, 0, 0, 0, 'h00);
        step(1, "ill_w1",   0, 1, 0, 0, 0, 0, 0, 0, 'h11);
        step(1, "ill_w2",   0, 1, 0, 0, 0, 0, 0, 0, 'h11);
        step(1, "ill_w3",   0, 1, 0, 0, 0, 0, 1, 0, 'h11);
        step(1, "ill_ld1",  0, 1, 1, 1, 0, 0, 0, 1, 'h11);
        step(1, "ill_b1",   0, 1, 0, 0, 0, 0, 0, 1, 'h22);
        step(1, "ill_b2",   0, 1, 0, 0, 0, 0, 0, 1, 'h22);
        step(1, "ill_b3",   0, 1, 0, 0, 0, 0, 1, 1, 'h22);
        step(1, "ill_sd3",  0, 1, 1, 3, 0, 1, 1, 1, 'h22);
        step(1, "ill_st1",  0, 1, 0, 0, 0, 1, 1, 1, 'h22);
        step(1, "ill_st2",  0, 1, 0, 0, 0, 1, 1, 1, 'h22);
        step(1, "ill_legal", 0, 1, 1, 2, 0, 1, 0, 2, 'h22);
        step(1, "ill_clr",  1, 1, 0, 0, 0, 0, 0, 0, 'h00);

        // randomized run on both instances against the model
        ma = '{ch: 0, dwell: 0, blank: 0, z: 0, zv: 1'b0, serr: 1'b0};
        mb = ma;
        r_au = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r_lsr = (i == 0) || ($urandom_range(0, 59) == 0);
            r_ce  = ($urandom_range(0, 3) != 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_sd  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) r_au = ~r_au;
            d = $urandom;
            ma = mdl_step(ma, NA, DWA, BLA, r_lsr, r_ce, r_ld, r_sd, r_au, d);
            mb = mdl_step(mb, NB, DWB, BLB, r_lsr, r_ce, r_ld, r_sd, r_au, d);
            exp_q.push_back(pack(ma.serr, ma.zv, ma.ch, ma.z));
            exp_q.push_back(pack(mb.serr, mb.zv, mb.ch, mb.z));
            drive(r_lsr, r_ce, r_ld, r_sd, r_au);
            check($sformatf("rnd_a%0d", i), act_a());
            check($sformatf("rnd_b%0d", i), act_b());
        end

        // final report
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
